// File: rtl/mx_rcvr.sv
// Manchester receiver: hunts for the 55 55 D0 preamble/SFD, then decodes
// LSB-first bytes until the line goes quiet, flagging clean or broken frames.
module mx_rcvr #(
   parameter int CLK_FREQ = 100_000_000,
   parameter int BIT_RATE = 50_000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rxd,
   output logic [7:0] data,
   output logic       valid,
   output logic       cardet,
   output logic       eof,
   output logic       err
);

   localparam int BIT_CLKS = CLK_FREQ / BIT_RATE;
   localparam int TW = $clog2(5 * BIT_CLKS / 4 + 1);
   localparam logic [TW-1:0] T_LO = TW'(3 * BIT_CLKS / 4);
   localparam logic [TW-1:0] T_HI = TW'(5 * BIT_CLKS / 4);
   localparam logic [7:0] SFD = 8'hD0;

   typedef enum logic {HUNT, RECV} state_t;

   state_t        state;
   logic          rxd_p0, rxd_p1, rxd_p2;
   logic          edge_p3, bit_p3;
   logic [TW-1:0] tmr;
   logic          armed;
   logic [15:0]   sr;
   logic [7:0]    byte_sr;
   logic [2:0]    bit_cnt;
   logic [7:0]    byte_cnt;

   logic          accept, timeout;
   logic [15:0]   sr_nxt;
   logic [7:0]    byte_nxt;

   // Synchronizer stages p0/p1 plus history p2; edge and bit registered into p3
   always_ff @(posedge clk) begin
      if (rst) begin
         rxd_p0  <= 1'b1;
         rxd_p1  <= 1'b1;
         rxd_p2  <= 1'b1;
         edge_p3 <= 1'b0;
         bit_p3  <= 1'b1;
      end else begin
         rxd_p0  <= rxd;
         rxd_p1  <= rxd_p0;
         rxd_p2  <= rxd_p1;
         edge_p3 <= rxd_p1 ^ rxd_p2;
         bit_p3  <= rxd_p1;
      end
   end

   // An armed (idle) timer takes any edge; otherwise only the mid-bit window counts
   assign accept   = edge_p3 && (armed || (tmr >= T_LO && tmr <= T_HI));
   assign timeout  = !armed && (tmr == T_HI) && !accept;
   assign sr_nxt   = {bit_p3, sr[15:1]};
   assign byte_nxt = {bit_p3, byte_sr[7:1]};

   // Decode stage: state machine and registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= HUNT;
         armed    <= 1'b1;
         tmr      <= '0;
         sr       <= '0;
         byte_sr  <= '0;
         bit_cnt  <= '0;
         byte_cnt <= '0;
         data     <= '0;
         valid    <= 1'b0;
         cardet   <= 1'b0;
         eof      <= 1'b0;
         err      <= 1'b0;
      end else begin
         valid <= 1'b0;
         eof   <= 1'b0;
         err   <= 1'b0;
         if (accept) begin
            tmr   <= '0;
            armed <= 1'b0;
            case (state)
               HUNT: begin
                  sr <= sr_nxt;
                  if (sr_nxt == {SFD, 8'h55}) begin
                     state    <= RECV;
                     cardet   <= 1'b1;
                     bit_cnt  <= '0;
                     byte_cnt <= '0;
                  end
               end
               RECV: begin
                  byte_sr <= byte_nxt;
                  bit_cnt <= bit_cnt + 3'd1;
                  if (bit_cnt == 3'd7) begin
                     data  <= byte_nxt;
                     valid <= 1'b1;
                     if (byte_cnt != 8'hFF)
                        byte_cnt <= byte_cnt + 8'd1;
                  end
               end
               default: state <= HUNT;
            endcase
         end else if (timeout) begin
            armed <= 1'b1;
            tmr   <= '0;
            sr    <= '0;
            if (state == RECV) begin
               state  <= HUNT;
               cardet <= 1'b0;
               if (bit_cnt == 3'd0 && byte_cnt != 8'd0)
                  eof <= 1'b1;
               else
                  err <= 1'b1;
            end
         end else if (!armed) begin
            tmr <= tmr + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_mx_rcvr.sv
// Directed bench for mx_rcvr: a Manchester frame generator pushes expected
// byte/eof/err events to a scoreboard that a negedge monitor drains.
module tb_mx_rcvr;

   localparam int CLKS = 80;

   logic       clk = 1'b0;
   logic       rst, rxd;
   logic [7:0] data;
   logic       valid, cardet, eof, err;

   mx_rcvr #(.CLK_FREQ(100_000_000), .BIT_RATE(1_250_000)) dut (
      .clk(clk), .rst(rst), .rxd(rxd), .data(data),
      .valid(valid), .cardet(cardet), .eof(eof), .err(err)
   );

   always #5 clk = ~clk;

   typedef struct {
      int         kind;   // 0 byte, 1 eof, 2 err
      logic [7:0] val;
   } ev_t;

   ev_t        sbq[$];
   ev_t        mon_e;
   int         checks = 0;
   int         errors = 0;
   bit         cardet_seen = 1'b0;
   logic [7:0] pay[16];
   int         pay_n = 0;

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic expect_ev(input int k, input logic [7:0] v);
      ev_t e;
      e.kind = k;
      e.val  = v;
      sbq.push_back(e);
   endtask

   task automatic load_std();
      pay[0] = 8'h5A; pay[1] = 8'h44; pay[2] = 8'h30;
      pay[3] = 8'h68; pay[4] = 8'h69; pay[5] = 8'h04;
      pay_n = 6;
   endtask

   // Line low->high at mid-bit means 1; optional short low glitch 0.3T after mid-bit
   task automatic send_bit(input logic b, input int t, input bit gl);
      rxd = ~b;
      tick(t / 2);
      rxd = b;
      if (gl && b) begin
         tick(t * 3 / 10);
         rxd = 1'b0;
         tick(4);
         rxd = 1'b1;
         tick(t - t / 2 - t * 3 / 10 - 4);
      end else begin
         tick(t - t / 2);
      end
   endtask

   task automatic send_byte(input logic [7:0] v, input int t, input bit gl);
      for (int i = 0; i < 8; i++) send_bit(v[i], t, gl);
   endtask

   task automatic send_frame(input int t, input bit gl, input int rst_after, input int extra);
      if (rst_after >= 0) begin
         for (int i = 0; i <= rst_after; i++) expect_ev(0, pay[i]);
      end else begin
         for (int i = 0; i < pay_n; i++) expect_ev(0, pay[i]);
         expect_ev((extra > 0 || pay_n == 0) ? 2 : 1, 8'h00);
      end
      send_byte(8'h55, t, 1'b0);
      send_byte(8'h55, t, gl);
      send_byte(8'hD0, t, gl);
      for (int i = 0; i < pay_n; i++) begin
         send_byte(pay[i], t, gl);
         if (i == rst_after) begin
            rst = 1'b1;
            tick(1);
            check("rst_mid_data", {24'h0, data}, 32'h0);
            check("rst_mid_valid", {31'h0, valid}, 32'h0);
            check("rst_mid_cardet", {31'h0, cardet}, 32'h0);
            check("rst_mid_eof", {31'h0, eof}, 32'h0);
            check("rst_mid_err", {31'h0, err}, 32'h0);
            rst = 1'b0;
         end
      end
      for (int i = 0; i < extra; i++) send_bit(logic'(i % 2), t, 1'b0);
      rxd = 1'b1;
      tick(4 * t);
   endtask

   // Every output pulse must match the head of the scoreboard
   always @(negedge clk) begin
      if (cardet) cardet_seen = 1'b1;
      if (!rst && (valid || eof || err)) begin
         check("pulse_exclusive", 32'(valid) + 32'(eof) + 32'(err), 32'd1);
         checks++;
         assert (sbq.size() > 0) else begin
            errors++;
            $error("FAIL unexpected_event: observed valid=%0b eof=%0b err=%0b data=%0h expected none",
                   valid, eof, err, data);
         end
         if (sbq.size() > 0) begin
            mon_e = sbq.pop_front();
            check("event_kind", valid ? 32'd0 : (eof ? 32'd1 : 32'd2), 32'(mon_e.kind));
            if (mon_e.kind == 0) check("byte_data", {24'h0, data}, {24'h0, mon_e.val});
            check("cardet_at_event", {31'h0, cardet}, (mon_e.kind == 0) ? 32'd1 : 32'd0);
         end
      end
   end

   initial begin
      #900_000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "simulation did not finish");
   end

   initial begin
      rxd = 1'b1;
      rst = 1'b1;
      tick(3);
      check("reset_data", {24'h0, data}, 32'h0);
      check("reset_valid", {31'h0, valid}, 32'h0);
      check("reset_cardet", {31'h0, cardet}, 32'h0);
      check("reset_eof", {31'h0, eof}, 32'h0);
      check("reset_err", {31'h0, err}, 32'h0);
      rst = 1'b0;
      tick(200);

      load_std();
      send_frame(CLKS, 1'b0, -1, 0);
      check("data_hold", {24'h0, data}, 32'h04);
      check("clean_drained", 32'(sbq.size()), 32'd0);

      pay_n = 1;
      send_frame(CLKS, 1'b0, -1, 3);
      check("trunc_drained", 32'(sbq.size()), 32'd0);

      pay_n = 0;
      send_frame(CLKS, 1'b0, -1, 0);
      check("empty_drained", 32'(sbq.size()), 32'd0);

      load_std();
      send_frame(CLKS, 1'b1, -1, 0);
      check("glitch_drained", 32'(sbq.size()), 32'd0);

      for (int i = 0; i < 40; i++) begin
         rxd = 1'($urandom_range(0, 1));
         tick(int'($urandom_range(5, 200)));
      end
      rxd = 1'b1;
      tick(400);
      cardet_seen = 1'b0;
      send_byte(8'hD0, CLKS, 1'b0);
      rxd = 1'b1;
      tick(400);
      check("false_lock_cardet", {31'h0, cardet_seen}, 32'h0);
      send_frame(CLKS, 1'b0, -1, 0);
      check("after_noise_drained", 32'(sbq.size()), 32'd0);

      send_frame(CLKS, 1'b0, 1, 0);
      check("rst_frame_drained", 32'(sbq.size()), 32'd0);
      send_frame(CLKS, 1'b0, -1, 0);
      check("post_rst_drained", 32'(sbq.size()), 32'd0);

      send_frame(72, 1'b0, -1, 0);
      check("fast_drained", 32'(sbq.size()), 32'd0);
      send_frame(88, 1'b0, -1, 0);
      check("slow_drained", 32'(sbq.size()), 32'd0);

      tick(100);
      check("final_drained", 32'(sbq.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
